dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_arb2.sv | 33 +++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-requester data-memory arbiter.
// The core (CORE) and the golden model (MODEL) share one single-port memory.
package dmem_arbiter_pkg;

  localparam int NUM_WORDS = 16;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_W    = 4;

  localparam logic CORE  = 1'b0;
  localparam logic MODEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin selector: on contention the grant goes to the
// requester that was not granted last. The pointer favours requester 0 after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);

  // requester that wins the next tie
  logic r_prio;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_grant = r_prio ? 2'b10 : 2'b01;
      end else begin
        o_grant = i_req;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (|o_grant) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and golden-model accesses onto one synchronous data memory,
// with same-cycle grants, one access per cycle, and a hold path for stalled responses.
module dmem_arbiter #(
  parameter int NUM_WORDS = 16,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [31:0]          req0_addr,
  input  logic [WORD_SIZE-1:0] req0_wdata,
  input  logic [3:0]           req0_wmask,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [WORD_SIZE-1:0] resp0_rdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [31:0]          req1_addr,
  input  logic [WORD_SIZE-1:0] req1_wdata,
  input  logic [3:0]           req1_wmask,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [WORD_SIZE-1:0] resp1_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [3:0]           mem_wmask,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1,
  output logic [1:0]           o_dbg_state
);

  import dmem_arbiter_pkg::*;

  // Handshake rules: a request transfers in a cycle where reqN_valid and
  // reqN_ready are both high; a response transfers where respN_valid and
  // respN_ready are both high. Requesters hold their request stable until ready.

  state_e                r_state;
  logic                  r_owner;
  logic                  r_we;
  logic [WORD_SIZE-1:0]  r_hold;
  logic [15:0]           r_cnt0;
  logic [15:0]           r_cnt1;

  logic                  w_resp_ack;
  logic                  w_grant_ok;
  logic [1:0]            w_grant;
  logic                  w_sel;
  logic [ADDR_W-1:0]     w_idx0;
  logic [ADDR_W-1:0]     w_idx1;
  logic                  w_resp_valid;
  logic [WORD_SIZE-1:0]  w_data;
  logic                  w_unused_addr;

  // byte offset is ignored; word index wraps modulo the memory depth
  assign w_idx0 = ADDR_W'(req0_addr[31:2] % 30'(NUM_WORDS));
  assign w_idx1 = ADDR_W'(req1_addr[31:2] % 30'(NUM_WORDS));
  assign w_unused_addr = &{1'b0, req0_addr[1:0], req1_addr[1:0]};

  assign w_resp_ack = (r_owner == MODEL) ? resp1_ready : resp0_ready;
  // gating with reset keeps every strobe low while reset is asserted
  assign w_grant_ok = !reset && ((r_state == IDLE) || ((r_state == RESP) && w_resp_ack));

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .i_req   ({req1_valid, req0_valid}),
    .i_en    (w_grant_ok),
    .o_grant (w_grant)
  );

  assign w_sel      = w_grant[1];
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign mem_en     = |w_grant;
  assign mem_we     = mem_en && (w_sel ? req1_we : req0_we);
  assign mem_addr   = w_sel ? w_idx1 : w_idx0;
  assign mem_wdata  = w_sel ? req1_wdata : req0_wdata;
  assign mem_wmask  = w_sel ? req1_wmask : req0_wmask;

  assign w_resp_valid = (r_state == RESP) || (r_state == HOLD);

  always_comb begin
    w_data = '0;
    if (r_state == HOLD) begin
      w_data = r_hold;
    end else if ((r_state == RESP) && !r_we) begin
      w_data = mem_rdata;
    end
  end

  assign resp0_valid = w_resp_valid && (r_owner == CORE);
  assign resp1_valid = w_resp_valid && (r_owner == MODEL);
  assign resp0_rdata = resp0_valid ? w_data : '0;
  assign resp1_rdata = resp1_valid ? w_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= CORE;
      r_we    <= 1'b0;
      r_hold  <= '0;
    end else begin
      if (mem_en) begin
        r_owner <= w_sel;
        r_we    <= mem_we;
      end
      case (r_state)
        IDLE: begin
          if (mem_en) r_state <= RESP;
        end
        RESP: begin
          if (!w_resp_ack) begin
            // memory data is only valid for one cycle, so park it
            r_hold  <= w_data;
            r_state <= HOLD;
          end else if (!mem_en) begin
            r_state <= IDLE;
          end
        end
        HOLD: begin
          if (w_resp_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_cnt0 != 16'hFFFF)) r_cnt0 <= r_cnt0 + 16'd1;
      if (req1_ready && (r_cnt1 != 16'hFFFF)) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0  = r_cnt0;
  assign grant_cnt1  = r_cnt1;
  assign o_dbg_state = r_state;

endmodule
